// File: rtl/fir_tap_dbuf.sv
// Double-buffered FIR coefficient store: taps arrive one word at a time into a shadow bank
// and are published to the active bank as a whole set, so the filter never sees a half-loaded set.
module fir_tap_dbuf #(
    parameter int DATA_WIDTH = 16,
    parameter int NB_TAPS    = 32,
    parameter bit REVERSE    = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              hold_i,
    input  logic                              h_serial_valid_i,
    input  logic [DATA_WIDTH-1:0]             h_serial_data_i,
    output logic                              h_serial_ready_o,
    output logic                              h_parallel_valid_o,
    output logic [DATA_WIDTH*NB_TAPS-1:0]     h_parallel_data_o,
    input  logic                              h_parallel_ready_i,
    output logic [$clog2(NB_TAPS+1)-1:0]      load_count_o,
    output logic                              swap_o
);

    localparam int CNT_W = $clog2(NB_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB_TAPS - 1);

    logic signed [DATA_WIDTH-1:0] shadow_p0 [NB_TAPS];
    logic [CNT_W-1:0]             cnt_p0;
    logic                         vld_p0;
    logic signed [DATA_WIDTH-1:0] active_p1 [NB_TAPS];
    logic                         vld_p1;
    logic                         swap_p1;

    logic                         s_hs;
    logic                         p_hs;
    logic                         do_swap;
    logic [CNT_W-1:0]             wr_idx;

    // Ready depends only on the full flag, keeping the serial side free of input-to-output paths.
    assign h_serial_ready_o = !vld_p0;
    assign s_hs             = h_serial_valid_i & !vld_p0;
    assign p_hs             = vld_p1 & h_parallel_ready_i;
    assign do_swap          = vld_p0 & (!vld_p1 | p_hs);
    assign wr_idx           = REVERSE ? (LAST_IDX - cnt_p0) : cnt_p0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_p0  <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            swap_p1 <= 1'b0;
        end else if (clear_i) begin
            cnt_p0  <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            swap_p1 <= 1'b0;
        end else begin
            swap_p1 <= do_swap;
            if (do_swap) begin
                vld_p1 <= 1'b1;
                vld_p0 <= 1'b0;
            end else if (p_hs && !hold_i) begin
                vld_p1 <= 1'b0;
            end
            // s_hs and do_swap are mutually exclusive: serial accept needs the shadow not full.
            if (s_hs) begin
                if (cnt_p0 == LAST_IDX) begin
                    cnt_p0 <= '0;
                    vld_p0 <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
            end
        end
    end

    // Stage p0: shadow bank, filled one slot per serial handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_TAPS; i++) shadow_p0[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NB_TAPS; i++) shadow_p0[i] <= '0;
        end else if (s_hs) begin
            for (int i = 0; i < NB_TAPS; i++) begin
                if (wr_idx == CNT_W'(i)) shadow_p0[i] <= h_serial_data_i;
            end
        end
    end

    // Stage p1: active bank, replaced in one edge on swap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_TAPS; i++) active_p1[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NB_TAPS; i++) active_p1[i] <= '0;
        end else if (do_swap) begin
            for (int i = 0; i < NB_TAPS; i++) active_p1[i] <= shadow_p0[i];
        end
    end

    for (genvar g = 0; g < NB_TAPS; g++) begin : g_pack
        assign h_parallel_data_o[g*DATA_WIDTH +: DATA_WIDTH] = active_p1[g];
    end

    assign h_parallel_valid_o = vld_p1;
    assign load_count_o       = cnt_p0;
    assign swap_o             = swap_p1;

endmodule
